// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: register address, write-port request,
// and a helper that turns a candidate write into a register-file request.
package wb_pkg;

  localparam int WB_XLEN = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic                we;
    reg_addr_t           addr;
    logic [WB_XLEN-1:0]  data;
  } wb_req_t;

  // Writes to x0 collapse to an all-zero request so they never reach the register file.
  function automatic wb_req_t make_req(input logic valid, input reg_addr_t addr,
                                       input logic [WB_XLEN-1:0] data);
    wb_req_t r;
    r = '0;
    if (valid && addr != REG_ZERO) begin
      r.we   = 1'b1;
      r.addr = addr;
      r.data = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between execute/memory side and the writeback arbiter.
// Forwarding signals exist only when WB_FWD_EN is defined.
interface wb_arbiter_if #(
  parameter int XLEN = 32
);
  import wb_pkg::*;

  logic             alu_valid;
  reg_addr_t        alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             load_req_valid;
  reg_addr_t        load_req_rd;
  logic             load_req_ready;
  logic             load_rsp_valid;
  logic [XLEN-1:0]  load_rsp_data;
  logic             load_rsp_ready;
  logic [31:0]      busy;
  logic             write_enable;
  reg_addr_t        write_address;
  logic [XLEN-1:0]  write_data;
`ifdef WB_FWD_EN
  reg_addr_t        rd_addr1;
  reg_addr_t        rd_addr2;
  logic             fwd_valid1;
  logic             fwd_valid2;
  logic [XLEN-1:0]  fwd_data1;
  logic [XLEN-1:0]  fwd_data2;

  modport slave (
    input  alu_valid, alu_rd, alu_data, load_req_valid, load_req_rd,
           load_rsp_valid, load_rsp_data, rd_addr1, rd_addr2,
    output load_req_ready, load_rsp_ready, busy, write_enable, write_address,
           write_data, fwd_valid1, fwd_valid2, fwd_data1, fwd_data2
  );
  modport master (
    output alu_valid, alu_rd, alu_data, load_req_valid, load_req_rd,
           load_rsp_valid, load_rsp_data, rd_addr1, rd_addr2,
    input  load_req_ready, load_rsp_ready, busy, write_enable, write_address,
           write_data, fwd_valid1, fwd_valid2, fwd_data1, fwd_data2
  );
`else
  modport slave (
    input  alu_valid, alu_rd, alu_data, load_req_valid, load_req_rd,
           load_rsp_valid, load_rsp_data,
    output load_req_ready, load_rsp_ready, busy, write_enable, write_address,
           write_data
  );
  modport master (
    output alu_valid, alu_rd, alu_data, load_req_valid, load_req_rd,
           load_rsp_valid, load_rsp_data,
    input  load_req_ready, load_rsp_ready, busy, write_enable, write_address,
           write_data
  );
`endif

endinterface

// File: rtl/wb_tag_fifo.sv
// Destination-tag FIFO for outstanding loads; pointers carry an extra wrap bit
// so full and empty are distinguishable without a counter.
module wb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results beat load responses, which park in a one-entry
// hold register when they lose. Optional forwarding is enabled by WB_FWD_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN      = WB_XLEN,
  parameter int TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);
  logic        fifo_full;
  logic        fifo_empty;
  reg_addr_t   tag_head;
  logic        req_ready;
  logic        issue;
  logic        rsp_accept;
  wb_req_t     alu_req;
  wb_req_t     rsp_req;
  wb_req_t     wr_next;
  wb_req_t     wr_reg;
  wb_req_t     hold_next;
  wb_req_t     hold_reg;
  logic [31:0] busy_next;
  logic [31:0] busy_reg;

  // Ready depends only on state and the requested rd, never on the response side.
  assign req_ready          = !fifo_full && !busy_reg[bus.load_req_rd];
  assign issue              = bus.load_req_valid && req_ready;
  assign rsp_accept         = bus.load_rsp_valid && !hold_reg.we && !fifo_empty;
  assign bus.load_req_ready = req_ready;
  assign bus.load_rsp_ready = !hold_reg.we;

  wb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH ($bits(reg_addr_t))
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (bus.load_req_rd),
    .pop       (rsp_accept),
    .head_data (tag_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign alu_req = make_req(1'b1, bus.alu_rd, WB_XLEN'(bus.alu_data));
  assign rsp_req = make_req(1'b1, tag_head, WB_XLEN'(bus.load_rsp_data));

  always_comb begin
    wr_next   = '0;
    hold_next = hold_reg;
    if (bus.alu_valid) begin
      wr_next = alu_req;
      if (rsp_accept) hold_next = rsp_req;
    end else if (hold_reg.we) begin
      wr_next   = hold_reg;
      hold_next = '0;
    end else if (rsp_accept) begin
      wr_next = rsp_req;
    end

    // Clear on commit first so a same-edge reissue to that rd keeps it busy.
    busy_next = busy_reg;
    if (wr_reg.we) busy_next[wr_reg.addr] = 1'b0;
    if (issue && bus.load_req_rd != REG_ZERO) busy_next[bus.load_req_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg   <= '0;
      hold_reg <= '0;
      busy_reg <= '0;
    end else begin
      wr_reg   <= wr_next;
      hold_reg <= hold_next;
      busy_reg <= busy_next;
    end
  end

  assign bus.busy          = busy_reg;
  assign bus.write_enable  = wr_reg.we;
  assign bus.write_address = wr_reg.addr;
  assign bus.write_data    = wr_reg.data[XLEN-1:0];

`ifdef WB_FWD_EN
  assign bus.fwd_valid1 = wr_reg.we && (wr_reg.addr == bus.rd_addr1) && (bus.rd_addr1 != REG_ZERO);
  assign bus.fwd_valid2 = wr_reg.we && (wr_reg.addr == bus.rd_addr2) && (bus.rd_addr2 != REG_ZERO);
  assign bus.fwd_data1  = wr_reg.data[XLEN-1:0];
  assign bus.fwd_data2  = wr_reg.data[XLEN-1:0];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a write-port scoreboard; define WB_FWD_EN
// to also exercise the forwarding outputs.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_arbiter_if #(.XLEN(32)) bus ();

  wb_arbiter #(.XLEN(32), .TAG_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    chk("alu_rd_not_busy", 32'(bus.busy[rd]), 32'd0);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
    if (rd != 5'd0) exp_q.push_back('{a: rd, d: d});
  endtask

  task automatic drive_rsp(input logic [4:0] rd, input logic [31:0] d);
    bus.load_rsp_valid = 1'b1;
    bus.load_rsp_data  = d;
    if (rd != 5'd0) exp_q.push_back('{a: rd, d: d});
  endtask

  // Scoreboard: every committed write must match the oldest expected one.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #2;
    if (rst_n && bus.write_enable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_write: observed addr %0d data %h, required no write",
               bus.write_address, bus.write_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", 32'(bus.write_address), 32'(e.a));
        chk("sb_data", bus.write_data, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    bus.alu_valid      = 1'b0;
    bus.alu_rd         = '0;
    bus.alu_data       = '0;
    bus.load_req_valid = 1'b0;
    bus.load_req_rd    = '0;
    bus.load_rsp_valid = 1'b0;
    bus.load_rsp_data  = '0;
`ifdef WB_FWD_EN
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
`endif
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_we", 32'(bus.write_enable), 32'd0);
    chk("rst_addr", 32'(bus.write_address), 32'd0);
    chk("rst_data", bus.write_data, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_req_ready", 32'(bus.load_req_ready), 32'd1);
    chk("rst_rsp_ready", 32'(bus.load_rsp_ready), 32'd1);
`ifdef WB_FWD_EN
    chk("rst_fwd_valid1", 32'(bus.fwd_valid1), 32'd0);
    chk("rst_fwd_data1", bus.fwd_data1, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // ALU only: one-cycle latency to the write port
    drive_alu(5'd5, 32'hDEADBEEF);
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_we", 32'(bus.write_enable), 32'd1);
    chk("alu_addr", 32'(bus.write_address), 32'd5);
    chk("alu_data", bus.write_data, 32'hDEADBEEF);
    tick();
    chk("alu_we_drop", 32'(bus.write_enable), 32'd0);

    // Collision: response loses to ALU, lands one cycle later
    bus.load_req_valid = 1'b1;
    bus.load_req_rd    = 5'd7;
    chk("col_req_ready", 32'(bus.load_req_ready), 32'd1);
    tick();
    bus.load_req_valid = 1'b0;
    chk("col_busy_set", 32'(bus.busy[7]), 32'd1);
    drive_alu(5'd3, 32'hA5A5A5A5);
    drive_rsp(5'd7, 32'h00001234);
    chk("col_rsp_ready", 32'(bus.load_rsp_ready), 32'd1);
    tick();
    bus.alu_valid      = 1'b0;
    bus.load_rsp_valid = 1'b0;
    chk("col_first_addr", 32'(bus.write_address), 32'd3);
    chk("col_hold_ready", 32'(bus.load_rsp_ready), 32'd0);
    tick();
    chk("col_second_addr", 32'(bus.write_address), 32'd7);
    chk("col_second_data", bus.write_data, 32'h00001234);
    chk("col_busy_before_commit", 32'(bus.busy[7]), 32'd1);
    tick();
    chk("col_busy_cleared", 32'(bus.busy[7]), 32'd0);
    chk("col_rsp_ready_back", 32'(bus.load_rsp_ready), 32'd1);

    // Hold waits through two consecutive ALU cycles
    bus.load_req_valid = 1'b1;
    bus.load_req_rd    = 5'd8;
    tick();
    bus.load_req_valid = 1'b0;
    drive_alu(5'd10, 32'h10);
    drive_rsp(5'd8, 32'h88);
    tick();
    bus.load_rsp_valid = 1'b0;
    exp_q.pop_back();
    drive_alu(5'd11, 32'h11);
    tick();
    bus.alu_valid = 1'b0;
    exp_q.push_back('{a: 5'd8, d: 32'h88});
    chk("hold_wait_addr", 32'(bus.write_address), 32'd11);
    chk("hold_wait_ready", 32'(bus.load_rsp_ready), 32'd0);
    tick();
    chk("hold_release_addr", 32'(bus.write_address), 32'd8);
    tick();

    // Backpressure and pointer wrap over three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 4; i++) begin
        if (i > 1) begin
          bus.load_req_rd = 5'(i - 1);
          #1;
          chk("bp_repeat_rd_refused", 32'(bus.load_req_ready), 32'd0);
        end
        bus.load_req_valid = 1'b1;
        bus.load_req_rd    = 5'(i);
        #1;
        chk("bp_issue_ready", 32'(bus.load_req_ready), 32'd1);
        tick();
      end
      bus.load_req_rd = 5'd5;
      d = 32'hB0000000 | (32'(r) << 8) | 32'd1;
      drive_rsp(5'd1, d);
      #1;
      chk("bp_full_refused", 32'(bus.load_req_ready), 32'd0);
      chk("bp_full_rsp_ready", 32'(bus.load_rsp_ready), 32'd1);
      tick();
      bus.load_req_valid = 1'b0;
      chk("bp_refused_not_busy", 32'(bus.busy[5]), 32'd0);
      for (int i = 2; i <= 4; i++) begin
        drive_rsp(5'(i), 32'hB0000000 | (32'(r) << 8) | 32'(i));
        tick();
      end
      bus.load_rsp_valid = 1'b0;
      repeat (2) tick();
      chk("bp_round_busy_clear", bus.busy, 32'd0);
    end

    // rd=0 load consumes a tag but never writes or sets busy
    bus.load_req_valid = 1'b1;
    bus.load_req_rd    = 5'd0;
    #1;
    chk("rd0_req_ready", 32'(bus.load_req_ready), 32'd1);
    tick();
    bus.load_req_valid = 1'b0;
    chk("rd0_busy", bus.busy, 32'd0);
    drive_rsp(5'd0, 32'h0000FFFF);
    tick();
    bus.load_rsp_valid = 1'b0;
    chk("rd0_no_we", 32'(bus.write_enable), 32'd0);
    for (int i = 12; i <= 15; i++) begin
      bus.load_req_valid = 1'b1;
      bus.load_req_rd    = 5'(i);
      #1;
      chk("rd0_tag_freed_ready", 32'(bus.load_req_ready), 32'd1);
      tick();
    end
    bus.load_req_rd = 5'd16;
    #1;
    chk("rd0_then_full", 32'(bus.load_req_ready), 32'd0);
    bus.load_req_valid = 1'b0;
    for (int i = 12; i <= 15; i++) begin
      drive_rsp(5'(i), 32'hC0DE0000 | 32'(i));
      tick();
    end
    bus.load_rsp_valid = 1'b0;
    repeat (2) tick();

    // Response with the FIFO empty is ignored but still accepted
    bus.load_rsp_valid = 1'b1;
    bus.load_rsp_data  = 32'hBAD0BAD0;
    #1;
    chk("empty_rsp_ready", 32'(bus.load_rsp_ready), 32'd1);
    tick();
    bus.load_rsp_valid = 1'b0;
    chk("empty_rsp_no_we", 32'(bus.write_enable), 32'd0);

`ifdef WB_FWD_EN
    drive_alu(5'd9, 32'h55);
    bus.rd_addr1 = 5'd9;
    bus.rd_addr2 = 5'd4;
    tick();
    bus.alu_valid = 1'b0;
    chk("fwd_valid1_hit", 32'(bus.fwd_valid1), 32'd1);
    chk("fwd_data1", bus.fwd_data1, 32'h55);
    chk("fwd_valid2_miss", 32'(bus.fwd_valid2), 32'd0);
    bus.rd_addr1 = 5'd0;
    #1;
    chk("fwd_valid1_x0", 32'(bus.fwd_valid1), 32'd0);
    tick();
`endif

    // Reset with three loads outstanding and a write on the port
    for (int i = 20; i <= 22; i++) begin
      bus.load_req_valid = 1'b1;
      bus.load_req_rd    = 5'(i);
      tick();
    end
    bus.load_req_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 32'h00700000);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd6;
    bus.alu_data  = 32'h66;
    tick();
    bus.alu_valid = 1'b0;
    chk("pre_rst_we", 32'(bus.write_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.write_enable), 32'd0);
    chk("mid_rst_data", bus.write_data, 32'd0);
    chk("mid_rst_busy", bus.busy, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.load_req_rd = 5'd20;
    #1;
    chk("post_rst_req_ready", 32'(bus.load_req_ready), 32'd1);
    chk("post_rst_busy", bus.busy, 32'd0);
    bus.load_rsp_valid = 1'b1;
    bus.load_rsp_data  = 32'h20202020;
    tick();
    bus.load_rsp_valid = 1'b0;
    chk("post_rst_fifo_empty", 32'(bus.write_enable), 32'd0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that owns the register file's single write port. It merges a fixed-latency ALU result stream with in-order, variable-latency load responses. A tag FIFO records the destination of every outstanding load, and a busy scoreboard lets decode stall on pending destinations. It sits between the execute/memory side of the 3-stage pipeline and the register file write inputs (write_enable, write_address, write_data).

## Interface
- XLEN, 32, data width
- TAG_DEPTH, 4, max outstanding loads (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid this cycle (never stalled)
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- load_req_valid  in  1  load issue
- load_req_rd  in  5  load destination
- load_req_ready  out  1  issue accepted when valid&ready
- load_rsp_valid  in  1  load data returned (in issue order)
- load_rsp_data  in  XLEN  load data
- load_rsp_ready  out  1  response accepted when valid&ready
- busy  out  32  per-register pending-load scoreboard, bit 0 always 0
- write_enable  out  1  to register file
- write_address  out  5  to register file
- write_data  out  XLEN  to register file
- rd_addr1, rd_addr2  in  5 each  decode read addresses (only with WB_FWD_EN)
- fwd_valid1, fwd_valid2  out  1 each  forward hit (only with WB_FWD_EN)
- fwd_data1, fwd_data2  out  XLEN each  forwarded value (only with WB_FWD_EN)

## Operation
- Write port outputs are registered. Reset value of write_enable, write_address, write_data, busy and fwd_* is 0.
- Priority each cycle, highest first:
  - alu_valid.
  - Hold register, if valid.
  - Accepted load response.
- Loser handling:
  - If an accepted response loses to the ALU, it is captured in a one-entry hold register (data plus popped rd).
  - If the hold register is valid and the ALU is active, the hold keeps waiting.
- load_rsp_ready = !hold_valid (registered-state only, no combinational path from inputs).
- Tag FIFO, TAG_DEPTH entries of 5-bit rd:
  - Push on issue handshake; pop on response handshake.
  - Pointers wrap modulo TAG_DEPTH, with an extra wrap bit for full/empty.
  - A response with the FIFO empty is a protocol error: it is ignored and ready is still asserted.
- load_req_ready = !full && !busy[load_req_rd]. A second load to an already-pending rd is refused.
- Scoreboard:
  - busy[rd] is set on the issue edge.
  - busy[rd] is cleared on the edge where the registered write_enable=1 and write_address=rd, i.e. the edge the register file commits the load.
  - Set and clear on the same edge for the same rd: set wins.
- rd=0 handling:
  - Loads with rd=0 still occupy a tag but never set busy.
  - Any write with rd=0 drives write_enable=0.
- An ALU write to a busy rd is not blocked. Decode must stall on busy; the bench flags this as an assertion.
- Reset mid-operation clears the FIFO, hold register, scoreboard and write port. In-flight loads are discarded.

## Timing
- ALU input to write_* valid: 1 cycle. Register file commit: the following edge.
- Load response to write_*:
  - 1 cycle if uncontested.
  - 1+N cycles if it lands in hold, where N = consecutive ALU-valid cycles.
- Issue to busy visible: 1 cycle.
- Throughput: one register write per cycle. The load path sustains one response per cycle when the ALU is idle.
- Simultaneous issue and response with FIFO full: response pops and issue is refused. Ready is based on state at the start of the cycle.

## Configuration
- WB_FWD_EN defined:
  - fwd_validN = write_enable && write_address == rd_addrN && rd_addrN != 0 (combinational on registered write port).
  - fwd_dataN = write_data.
  - Covers the cycle before register file commit.
- WB_FWD_EN undefined:
  - rd_addr*/fwd_* ports are absent.
  - Decode must wait one extra cycle after a write before reading the written register.

## Structure
- Shared package wb_pkg holds:
  - typedef reg_addr_t (logic [4:0]).
  - typedef wb_req_t {we, addr, data}.
  - Constant REG_ZERO = 5'd0.
- Sub-module wb_tag_fifo holds the tag FIFO (parameterised depth and width, push/pop/full/empty).

## Test plan
- Reset: rst_n=0 mid-burst with 3 loads outstanding -> all outputs 0, busy=0, load_req_ready=1 after release.
- ALU only: alu_valid, rd=5, data=0xDEADBEEF -> next cycle write_enable=1, write_address=5, write_data=0xDEADBEEF.
- Collision:
  - Stimulus: load to rd=7 issued, then response 0x1234 in the same cycle as ALU write rd=3.
  - Required: rd=3 written first, rd=7/0x1234 written the next cycle, busy[7] clears on the commit edge.
- Backpressure and wrap:
  - Issue 4 loads (rd=1..4) -> load_req_ready=0 when full and for a repeated busy rd.
  - Return responses in order -> writes to rd 1..4 in order.
  - Repeat for 3 rounds so pointers wrap.
- rd=0 load: issue rd=0, return 0xFFFF -> no write_enable, busy unchanged, tag consumed.
- WB_FWD_EN: ALU write rd=9 data=0x55 with rd_addr1=9 -> fwd_valid1=1, fwd_data1=0x55 in the write_* cycle; rd_addr1=0 -> fwd_valid1=0.
